pipe_reg_elastic: RTL and testbench
===================================

Name: pipe_reg_elastic

Overview:
Parametrised elastic pipeline register, the successor to the fixed-width inter-stage registers in the pipelined datapath. It carries a packed data payload, a control field and an instruction-valid flag across a stage boundary. Beyond plain latching it adds:
- a valid/ready handshake backed by a one-entry skid buffer, so downstream back-pressure needs no combinational ready path;
- a synchronous flush that inserts bubbles;
- a retired-instruction counter.

Intended first use is the MEM/WB boundary, with the hazard unit driving out_ready and flush.

Parameters:
DATA_W, 69, payload width (default packs readData 32 + ALUOut 32 + dest reg 5)
CTRL_W, 2, control-bit width (default {regWrite, memToReg})
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  datapath clock; all state updates on negedge clk
reset  in  1  synchronous, active-high reset, sampled on negedge clk
flush  in  1  synchronous bubble insert; discards all held entries
in_valid  in  1  upstream holds an instruction (haveInstr)
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
out_valid  out  1  main entry holds an instruction
out_ready  in  1  downstream accepts
out_data  out  DATA_W  main-entry payload
out_ctrl  out  CTRL_W  main-entry control; 0 whenever out_valid=0
occupancy  out  2  entries held: 0, 1 or 2
retired_count  out  CNT_W  count of completed output transfers

Behaviour:
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated from values present just before the negedge.
- Storage: a main entry {valid, data, ctrl} and a skid entry {valid, data, ctrl}.
- States, encoded as occupancy: EMPTY=0, ONE=1, TWO=2.
- Reset:
  - All outputs go to 0 except in_ready=1: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, retired_count=0.
  - Both entries are cleared.
- Priority at each negedge: reset > flush > handshake.
- Transitions:
  - EMPTY: push -> ONE, main<=in. No push -> stay EMPTY.
  - ONE, push & pop -> ONE, main<=in (full throughput).
  - ONE, push & !pop -> TWO, skid<=in, main unchanged.
  - ONE, !push & pop -> EMPTY, main data/ctrl cleared to 0.
  - ONE, neither -> hold.
  - TWO: in_ready=0, so push cannot occur. pop -> ONE, main<=skid, skid cleared. No pop -> hold.
- Latency: 1 negedge from push to out_valid when empty. Throughput is 1 transfer per cycle while out_ready=1.
- in_ready is registered. It drops on the edge that fills the skid entry and rises on the edge that drains it. A push is therefore never lost when out_ready falls.
- Bubble rule: an empty main entry always presents ctrl=0, so regWrite=0 for bubbles. Payload ordering is strict FIFO.
- Flush:
  - Next state is EMPTY; both entries are cleared; in_ready=1.
  - A push on the flush edge is discarded.
  - A pop on the flush edge still counts as retired, because downstream already consumed it.
- retired_count:
  - +1 on each pop edge, including a pop on a flush edge; wraps modulo 2^CNT_W.
  - Cleared only by reset; unaffected by flush.
- Reset asserted mid-stream: every entry is lost and the counter is zeroed at that edge. No partial updates.
- occupancy always equals main.valid + skid.valid. The value 3 is illegal, and the verifier must assert it never occurs.

Decomposition:
- Shared package pipe_pkg holds:
  - occupancy constants OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2;
  - default width constants (DATA_W_MEMWB=69, CTRL_W_MEMWB=2);
  - the payload packing order {readData, ALUOut, destReg}.
- One natural sub-module: pipe_entry, a single {valid, data, ctrl} register with load/clear enables, instantiated twice (main, skid).

Test Plan:
- Reset then idle: assert reset for 2 cycles -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, retired_count=0.
- Streaming: in_valid=1, out_ready=1, data 0x1..0x5 on consecutive cycles -> out_data 0x1..0x5 each 1 negedge later, occupancy=1 throughout, retired_count=5.
- Back-pressure: push 0xA, 0xB with out_ready=0 -> occupancy=2 and in_ready=0 after the 2nd edge; a third offer 0xC is held upstream; raising out_ready delivers 0xA, 0xB, 0xC in order with no loss or duplication.
- Flush while TWO with out_ready=1: flush=1 for one edge -> occupancy=0, out_valid=0, out_ctrl=0, retired_count incremented by exactly 1.
- Counter wrap: CNT_W=4, 17 transfers -> retired_count=1.
- Reset mid-operation at occupancy=2 with in_valid=1 -> all outputs return to reset values on that edge; the offered input is not captured.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register:
// occupancy encoding, MEM/WB default widths and the payload packing order.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int DATA_W_MEMWB = 69;
  localparam int CTRL_W_MEMWB = 2;

  // MEM/WB payload, most significant field first
  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  dest_reg;
  } memwb_payload_t;

  function automatic logic [DATA_W_MEMWB-1:0] pack_memwb(
    input logic [31:0] read_data,
    input logic [31:0] alu_out,
    input logic [4:0]  dest_reg
  );
    memwb_payload_t p;
    p.read_data = read_data;
    p.alu_out   = alu_out;
    p.dest_reg  = dest_reg;
    return p;
  endfunction

endpackage

// File: rtl/pipe_reg_elastic_if.sv
// Valid/ready stream bundle: the master drives payload and valid, the slave
// answers with ready.
interface pipe_reg_elastic_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_MEMWB,
  parameter int CTRL_W = CTRL_W_MEMWB
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_entry.sv
// One {valid, data, ctrl} storage slot with load and clear enables; clear
// wins over load so an empty slot always presents zero payload and control.
module pipe_entry #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values;
  // the payload is reset too, since bubbles must show ctrl=0 from the first cycle.
  always_ff @(negedge clk) begin
    if (reset || i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_ld) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: main entry plus one skid entry so in_ready is
// registered, with synchronous flush and a retired-instruction counter.
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_MEMWB,
  parameter int CTRL_W = CTRL_W_MEMWB,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_reg_elastic_if.slave  in_if,
  pipe_reg_elastic_if.master out_if,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  retired_count
);

  occ_e r_state, w_next;
  logic w_push, w_pop;
  logic w_ld_main_in, w_ld_main_skid, w_clr_main, w_ld_skid, w_clr_skid;
  logic              w_main_valid, w_skid_valid;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_d;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_c;
  logic [CNT_W-1:0]  r_retired;

  assign w_push = in_if.valid & in_if.ready;
  assign w_pop  = w_main_valid & out_if.ready;

  always_ff @(negedge clk) begin
    if (reset) r_state <= OCC_EMPTY;
    else       r_state <= w_next;
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_clr_main     = 1'b0;
    w_ld_skid      = 1'b0;
    w_clr_skid     = 1'b0;
    if (flush) begin
      w_next     = OCC_EMPTY;
      w_clr_main = 1'b1;
      w_clr_skid = 1'b1;
    end else begin
      unique case (r_state)
        OCC_EMPTY: if (w_push) begin
          w_next       = OCC_ONE;
          w_ld_main_in = 1'b1;
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_push) begin
            w_next    = OCC_TWO;
            w_ld_skid = 1'b1;
          end else if (w_pop) begin
            w_next     = OCC_EMPTY;
            w_clr_main = 1'b1;
          end
        end
        OCC_TWO: if (w_pop) begin
          w_next         = OCC_ONE;
          w_ld_main_skid = 1'b1;
          w_clr_skid     = 1'b1;
        end
        default: w_next = OCC_EMPTY;
      endcase
    end
  end

  assign w_main_d = w_ld_main_skid ? w_skid_data : in_if.data;
  assign w_main_c = w_ld_main_skid ? w_skid_ctrl : in_if.ctrl;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr_main),
    .i_ld    (w_ld_main_in | w_ld_main_skid),
    .i_data  (w_main_d),
    .i_ctrl  (w_main_c),
    .o_valid (w_main_valid),
    .o_data  (w_main_data),
    .o_ctrl  (w_main_ctrl)
  );

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr_skid),
    .i_ld    (w_ld_skid),
    .i_data  (in_if.data),
    .i_ctrl  (in_if.ctrl),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_ctrl  (w_skid_ctrl)
  );

  // A pop on a flush edge still retires: downstream has already taken it
  always_ff @(negedge clk) begin
    if (reset)      r_retired <= '0;
    else if (w_pop) r_retired <= r_retired + 1'b1;
  end

  assign in_if.ready   = ~w_skid_valid;
  assign out_if.valid  = w_main_valid;
  assign out_if.data   = w_main_data;
  assign out_if.ctrl   = w_main_ctrl;
  assign occupancy     = r_state;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic: reference occupancy/counter model plus
// a FIFO scoreboard of pushed payloads, checked around every negedge.
module tb_pipe_reg_elastic;
  import pipe_pkg::*;

  localparam int DW = 69;
  localparam int CW = 2;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic [1:0]    occupancy;
  logic [NW-1:0] retired_count;

  pipe_reg_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_reg_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  pipe_reg_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_if         (up_if.slave),
    .out_if        (dn_if.master),
    .occupancy     (occupancy),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            m_occ = 0;
  logic [NW-1:0] m_cnt = '0;
  logic [DW-1:0] q_data[$];
  logic [CW-1:0] q_ctrl[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = d[CW-1:0] ^ 2'b01;
    dn_if.ready = r;
  endtask

  // One negedge: pop checks before the edge, state checks just after it
  task automatic tick();
    logic push, pop;
    push = up_if.valid && (m_occ != 2);
    pop  = !reset && (m_occ != 0) && dn_if.ready;
    if (pop) begin
      if (q_data.size() == 0) begin
        check("sb_underflow", 1'b1, 1'b0);
      end else begin
        check("pop_data", dn_if.data, q_data.pop_front());
        check("pop_ctrl", dn_if.ctrl, q_ctrl.pop_front());
      end
      m_cnt = m_cnt + 1'b1;
    end
    @(negedge clk);
    #1;
    if (reset) begin
      q_data.delete(); q_ctrl.delete();
      m_occ = 0;
      m_cnt = '0;
    end else if (flush) begin
      q_data.delete(); q_ctrl.delete();
      m_occ = 0;
    end else begin
      if (push) begin
        q_data.push_back(up_if.data);
        q_ctrl.push_back(up_if.ctrl);
      end
      m_occ = m_occ + int'(push) - int'(pop);
    end
    check("occ_legal", occupancy != 2'd3, 1'b1);
    check("occupancy", occupancy, m_occ);
    check("in_ready", up_if.ready, m_occ != 2);
    check("out_valid", dn_if.valid, m_occ != 0);
    check("retired", retired_count, m_cnt);
    if (m_occ == 0) begin
      check("bubble_ctrl", dn_if.ctrl, '0);
      check("bubble_data", dn_if.data, '0);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Reset, then idle
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_ready", up_if.ready, 1'b1);

    // Streaming 1..5 at full throughput, with one MEM/WB-packed payload
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, DW'(i), 1'b1);
      tick();
      check("stream_occ", occupancy, 2'd1);
      check("stream_data", dn_if.data, DW'(i));
    end
    drive(1'b1, pack_memwb(32'hDEAD_BEEF, 32'h1234_5678, 5'd17), 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    check("stream_cnt", retired_count, 4'd6);

    // Back-pressure: A, B fill both entries, C held upstream until drained
    drive(1'b1, 69'hA, 1'b0);
    tick();
    drive(1'b1, 69'hB, 1'b0);
    tick();
    check("bp_full_ready", up_if.ready, 1'b0);
    drive(1'b1, 69'hC, 1'b0);
    tick();
    drive(1'b1, 69'hC, 1'b1);
    tick();
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    check("bp_cnt", retired_count, 4'd9);

    // Flush while TWO with out_ready=1; the offered 0x13 is discarded
    drive(1'b1, 69'h11, 1'b0);
    tick();
    drive(1'b1, 69'h12, 1'b0);
    tick();
    drive(1'b1, 69'h13, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_cnt", retired_count, 4'd10);
    drive(1'b0, '0, 1'b1);
    tick();

    // Seven more transfers: 17 in total since reset wraps the 4-bit counter to 1
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, DW'($urandom), 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    tick();
    check("wrap_cnt", retired_count, 4'd1);

    // Reset mid-stream at occupancy 2 with a new offer pending
    drive(1'b1, 69'h21, 1'b0);
    tick();
    drive(1'b1, 69'h22, 1'b0);
    tick();
    drive(1'b1, 69'h23, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, '0, 1'b1);
    tick();
    check("post_rst_cnt", retired_count, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not complete");
  end

endmodule
